// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: processes one operand bit per clock, LSB first,
// through a single full adder. S, C and V are registered on completion and
// held until the next operation completes.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one bit processed per cycle, busy=1
// DONE  | results valid, done=1 for this single cycle
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V
);

    // Counter needs at least one bit so WIDTH=1 still elaborates.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic             v_q, v_d;

    logic ha0_s, ha0_c, ha1_c, fa_sum, fa_cout;

    // Full adder on the current LSBs: two half-adder stages plus an OR.
    always_comb begin
        ha0_s   = a_q[0] ^ b_q[0];
        ha0_c   = a_q[0] & b_q[0];
        fa_sum  = ha0_s ^ carry_q;
        ha1_c   = ha0_s & carry_q;
        fa_cout = ha0_c | ha1_c;
    end

    // Next-state, datapath updates and status outputs.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        s_d     = s_q;
        c_d     = c_q;
        v_d     = v_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    // Subtraction is A + ~B + 1, so the carry seeds to 1 and cin is unused.
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                busy    = 1'b1;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                res_d   = WIDTH'({fa_sum, res_q} >> 1);
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB, fa_cout the carry out of it.
                    s_d     = res_d;
                    c_d     = fa_cout;
                    v_d     = carry_q ^ fa_cout;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            s_q     <= s_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign S = s_q;
    assign C = c_q;
    assign V = v_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table plus scoreboard queue,
// with hand-written sequences for ignored start, mid-run reset, back-to-back
// operation and a WIDTH=1 instance.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, sub, cin;
    logic [7:0] A, B, S;
    logic       busy, done, C, V;

    logic       w1_start, w1_sub, w1_cin;
    logic [0:0] w1_A, w1_B, w1_S;
    logic       w1_busy, w1_done, w1_C, w1_V;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B), .cin(cin),
        .busy(busy), .done(done), .S(S), .C(C), .V(V)
    );

    serial_adder #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst(rst), .start(w1_start), .sub(w1_sub), .A(w1_A), .B(w1_B),
        .cin(w1_cin), .busy(w1_busy), .done(w1_done), .S(w1_S), .C(w1_C), .V(w1_V)
    );

    typedef struct packed {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       c;
        logic       v;
    } vec_t;

    int         n_checks = 0;
    int         n_errors = 0;
    vec_t       sb[$];
    vec_t       vecs[9];
    vec_t       b2b[3];
    logic [7:0] last_s;
    logic       last_c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_op(input vec_t v);
        start = 1'b1;
        sub   = v.sub;
        A     = v.a;
        B     = v.b;
        cin   = v.cin;
        sb.push_back(v);
    endtask

    task automatic pop_compare(input string tag);
        vec_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_S"}, S, e.s);
            chk({tag, "_C"}, C, e.c);
            chk({tag, "_V"}, V, e.v);
            last_s = e.s;
            last_c = e.c;
        end
    endtask

    // One complete operation; inject>0 pulses a junk start in that RUN cycle.
    task automatic run_op(input vec_t v, input int inject);
        int busy_cnt;
        bit seen;
        @(negedge clk);
        drive_op(v);
        @(negedge clk);
        start = 1'b0;
        A     = 8'($urandom);
        B     = 8'($urandom);
        sub   = 1'($urandom);
        cin   = 1'($urandom);
        chk("hold_S", S, last_s);
        chk("hold_C", C, last_c);
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            start = (inject != 0 && busy_cnt == inject);
            if (start) begin
                A   = ~v.a;
                B   = 8'h5A;
                sub = ~v.sub;
                cin = ~v.cin;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 1);
        chk("busy_cycles", busy_cnt, 8);
        chk("busy_in_done", busy, 0);
        pop_compare("op");
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_done, pend, w1_busy_cnt, w1_done_at, done_cnt;
        vec_t tmp;

        vecs[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'h10, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0};

        b2b[0] = '{1'b0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
        b2b[1] = '{1'b0, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0};
        b2b[2] = '{1'b1, 8'h50, 8'h20, 1'b0, 8'h30, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; A = '0; B = '0;
        w1_start = 1'b0; w1_sub = 1'b0; w1_cin = 1'b0; w1_A = '0; w1_B = '0;
        last_s = 8'h00;
        last_c = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_S", S, 0);
        chk("rst_C", C, 0);
        chk("rst_V", V, 0);
        chk("rst_w1_busy", w1_busy, 0);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i], 0);

        // Junk start in RUN cycle 3 must not disturb 7F+01.
        run_op(vecs[1], 3);

        // Reset mid-RUN.
        @(negedge clk);
        tmp = '{1'b0, 8'hAA, 8'h11, 1'b0, 8'hBB, 1'b0, 1'b0};
        drive_op(tmp);
        void'(sb.pop_back());
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_S", S, 0);
        chk("midrst_C", C, 0);
        chk("midrst_V", V, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("midrst_no_done", done_cnt, 0);
        last_s = 8'h00;
        last_c = 1'b0;
        run_op('{1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0}, 0);

        // Back-to-back with start held high across DONE.
        @(negedge clk);
        drive_op(b2b[0]);
        @(posedge clk);
        @(negedge clk);
        sub = b2b[1].sub; A = b2b[1].a; B = b2b[1].b; cin = b2b[1].cin;
        sb.push_back(b2b[1]);
        n_done = 0;
        pend   = 0;
        for (int j = 0; j < 40; j++) begin
            if (j != 0) @(negedge clk);
            if (pend == 1) begin
                sub = b2b[2].sub; A = b2b[2].a; B = b2b[2].b; cin = b2b[2].cin;
                sb.push_back(b2b[2]);
                pend = 0;
            end else if (pend == 2) begin
                start = 1'b0;
                pend  = 0;
            end
            if (done) begin
                chk("b2b_done_cycle", j, 8 + 9 * n_done);
                pop_compare("b2b");
                n_done++;
                if (n_done == 1) pend = 1;
                if (n_done == 2) pend = 2;
                if (n_done == 3) break;
            end
        end
        start = 1'b0;
        chk("b2b_count", n_done, 3);
        @(negedge clk);
        chk("b2b_end_done", done, 0);

        // WIDTH=1: 1 + 1.
        @(negedge clk);
        w1_start = 1'b1; w1_A = 1'b1; w1_B = 1'b1; w1_cin = 1'b0; w1_sub = 1'b0;
        @(posedge clk);
        w1_busy_cnt = 0;
        w1_done_at  = -1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            w1_start = 1'b0;
            if (w1_done) begin
                w1_done_at = j;
                break;
            end
            if (w1_busy) w1_busy_cnt++;
        end
        chk("w1_busy_cycles", w1_busy_cnt, 1);
        chk("w1_done_cycle", w1_done_at, 1);
        chk("w1_S", w1_S, 0);
        chk("w1_C", w1_C, 1);
        @(negedge clk);
        chk("w1_done_one_cycle", w1_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
